// File: rtl/tt_um_ay5876_dff_bank.sv
// Bank of DEPTH registered stages with shift, indexed load, clear and a combinational tap.
// Optional even-parity status bit on uio_out[5] is compiled in by defining DFF_BANK_PARITY_EN.
module tt_um_ay5876_dff_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [WIDTH-1:0] d;
    logic [1:0]       mode;
    logic [2:0]       sel;
    logic [WIDTH-1:0] tap_data;
    logic             tap_valid;
    logic             full;
    logic             parity;
    logic             unused_bits;

    assign d           = ui_in[WIDTH-1:0];
    assign mode        = uio_in[1:0];
    assign sel         = uio_in[4:2];
    assign unused_bits = &{1'b0, uio_in[7:5], ui_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
            valid <= '0;
        end else if (ena) begin
            case (mode)
                MODE_SHIFT: begin
                    stage[0] <= d;
                    for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
                    valid <= {valid[DEPTH-2:0], 1'b1};
                end
                MODE_LOAD: begin
                    // An out-of-range sel matches no stage, so the load is dropped.
                    for (int k = 0; k < DEPTH; k++) begin
                        if (sel == 3'(k)) begin
                            stage[k] <= d;
                            valid[k] <= 1'b1;
                        end
                    end
                end
                MODE_CLEAR: begin
                    for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
                    valid <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel == 3'(k)) begin
                tap_data  = stage[k];
                tap_valid = valid[k];
            end
        end
    end

    assign full = &valid;

`ifdef DFF_BANK_PARITY_EN
    assign parity = ^tap_data;
    assign uio_oe = 8'b1110_0000;
`else
    assign parity = 1'b0;
    assign uio_oe = 8'b1100_0000;
`endif

    always_comb begin
        uo_out             = '0;
        uo_out[WIDTH-1:0]  = tap_data;
        uio_out            = {full, tap_valid, parity, 5'b0_0000};
    end

endmodule

// File: tb/tb_tt_um_ay5876_dff_bank.sv
// Self-checking bench for tt_um_ay5876_dff_bank at WIDTH=8, DEPTH=4.
// Table-driven vectors with a scoreboard queue, plus hand sequences for reset and tap timing.
module tb_tt_um_ay5876_dff_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

`ifdef DFF_BANK_PARITY_EN
    localparam logic [7:0] EXP_OE = 8'hE0;
    localparam bit PAR_EN = 1'b1;
`else
    localparam logic [7:0] EXP_OE = 8'hC0;
    localparam bit PAR_EN = 1'b0;
`endif

    tt_um_ay5876_dff_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       ena;
        logic [1:0] mode;
        logic [2:0] sel;
        logic [7:0] d;
        logic [2:0] rsel;
        logic [7:0] exp_uo;
        logic       exp_full;
        logic       exp_tv;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pack_exp(input logic [7:0] uo, input logic full, input logic tv);
        logic par;
        par = PAR_EN ? ^uo : 1'b0;
        return {uo, full, tv, par, 5'b0};
    endfunction

    task automatic set_ctrl(input logic e, input logic [1:0] mode, input logic [2:0] sel, input logic [7:0] d);
        ena    = e;
        uio_in = {3'($urandom_range(0, 7)), sel, mode};
        ui_in  = d;
    endtask

    task automatic check_sb(input string name);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %02h/%02h expected an entry", name, uo_out, uio_out);
        end else begin
            e = exp_q.pop_front();
            check({name, ".uo_out"}, uo_out, e[15:8]);
            check({name, ".uio_out"}, uio_out, e[7:0]);
        end
    endtask

    // Drive one vector for an edge, then switch to HOLD at the read-back sel and compare.
    task automatic apply(input int i);
        @(negedge clk);
        set_ctrl(vecs[i].ena, vecs[i].mode, vecs[i].sel, vecs[i].d);
        exp_q.push_back(pack_exp(vecs[i].exp_uo, vecs[i].exp_full, vecs[i].exp_tv));
        @(negedge clk);
        set_ctrl(1'b1, 2'b00, vecs[i].rsel, 8'h00);
        #1;
        check_sb($sformatf("vec%0d", i));
    endtask

    initial begin
        //            ena mode   sel  d      rsel uo     full tv
        vecs[0]  = '{1, 2'b01, 0, 8'hA5, 0, 8'hA5, 0, 1};
        vecs[1]  = '{1, 2'b11, 0, 8'h00, 0, 8'h00, 0, 0};
        vecs[2]  = '{1, 2'b01, 0, 8'h11, 0, 8'h11, 0, 1};
        vecs[3]  = '{1, 2'b01, 0, 8'h22, 1, 8'h11, 0, 1};
        vecs[4]  = '{1, 2'b01, 0, 8'h33, 2, 8'h11, 0, 1};
        vecs[5]  = '{1, 2'b01, 0, 8'h44, 3, 8'h11, 1, 1};
        vecs[6]  = '{1, 2'b01, 0, 8'h55, 3, 8'h22, 1, 1};
        vecs[7]  = '{0, 2'b11, 0, 8'h00, 0, 8'h55, 1, 1};
        vecs[8]  = '{0, 2'b11, 0, 8'h00, 3, 8'h22, 1, 1};
        vecs[9]  = '{0, 2'b11, 0, 8'h00, 2, 8'h33, 1, 1};
        vecs[10] = '{1, 2'b11, 0, 8'h00, 3, 8'h00, 0, 0};
        vecs[11] = '{1, 2'b00, 0, 8'h99, 0, 8'h00, 0, 0};
        vecs[12] = '{1, 2'b10, 2, 8'h3C, 2, 8'h3C, 0, 1};
        vecs[13] = '{1, 2'b00, 1, 8'h00, 1, 8'h00, 0, 0};
        vecs[14] = '{1, 2'b10, 5, 8'hEE, 5, 8'h00, 0, 0};
        vecs[15] = '{1, 2'b00, 2, 8'h00, 2, 8'h3C, 0, 1};
        vecs[16] = '{1, 2'b10, 0, 8'h07, 0, 8'h07, 0, 1};
        vecs[17] = '{1, 2'b10, 0, 8'h03, 0, 8'h03, 0, 1};
        vecs[18] = '{1, 2'b01, 0, 8'h81, 3, 8'h3C, 0, 1};
        vecs[19] = '{1, 2'b00, 0, 8'h00, 2, 8'h00, 0, 0};
        vecs[20] = '{1, 2'b10, 2, 8'hF0, 2, 8'hF0, 1, 1};
        vecs[21] = '{0, 2'b01, 0, 8'h6B, 0, 8'h81, 1, 1};

        // Reset held while SHIFT of FF is requested with clock running.
        rst_n = 1'b0;
        set_ctrl(1'b1, 2'b01, 0, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset%0d.uo_out", c), uo_out, 8'h00);
            check($sformatf("reset%0d.uio_out", c), uio_out, 8'h00);
            check($sformatf("reset%0d.uio_oe", c), uio_oe, EXP_OE);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) apply(i);

        // LOAD target and tap share sel: old value visible until the edge.
        @(negedge clk);
        set_ctrl(1'b1, 2'b10, 1, 8'h5A);
        #1;
        check("tap_before_load", uo_out, 8'h03);
        @(negedge clk);
        #1;
        check("tap_after_load", uo_out, 8'h5A);

        // Asynchronous reset asserted mid-SHIFT, released before the next edge.
        @(negedge clk);
        set_ctrl(1'b1, 2'b01, 0, 8'h77);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.uo_out", uo_out, 8'h00);
        check("async_rst.uio_out", uio_out, 8'h00);
        check("async_rst.uio_oe", uio_oe, EXP_OE);
        #1 rst_n = 1'b1;
        @(negedge clk);
        set_ctrl(1'b1, 2'b00, 0, 8'h00);
        exp_q.push_back(pack_exp(8'h77, 1'b0, 1'b1));
        #1;
        check_sb("post_rst_stage0");
        set_ctrl(1'b1, 2'b00, 1, 8'h00);
        exp_q.push_back(pack_exp(8'h00, 1'b0, 1'b0));
        #1;
        check_sb("post_rst_stage1");
        check("final.uio_oe", uio_oe, EXP_OE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_ay5876_dff_bank.md
TT_UM_AY5876_DFF_BANK -- requirements
Module: tt_um_ay5876_dff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per stage, legal range 1..8.
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages, legal range 2..8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ena, input, 1, design-selected enable; low forces mode HOLD.
REQ-006 SHALL have port ui_in, input, 8, data D; bits [WIDTH-1:0] used, the rest ignored.
REQ-007 SHALL have port uio_in, input, 8, control: [1:0] mode, [4:2] sel, [7:5] ignored.
REQ-008 SHALL have port uo_out, output, 8, tap data = stage[sel], zero-extended above WIDTH.
REQ-009 SHALL have port uio_out, output, 8, status: [7] full, [6] tap_valid, [5] parity (see Configuration), [4:0] zero.
REQ-010 SHALL have port uio_oe, output, 8, constant output enables per Configuration.

Function
REQ-011 SHALL hold DEPTH stages of WIDTH data bits plus one valid bit per stage.
REQ-012 SHALL decode mode 00 = HOLD: no state change.
REQ-013 SHALL decode mode 01 = SHIFT: stage0 <= D, valid0 <= 1, stage k <= stage k-1 and valid k <= valid k-1 for k = 1..DEPTH-1; stage DEPTH-1 contents discarded.
REQ-014 SHALL decode mode 10 = LOAD: stage[sel] <= D, valid[sel] <= 1, other stages unchanged.
REQ-015 SHALL decode mode 11 = CLEAR: all stages and valid bits <= 0 synchronously.
REQ-016 SHALL ignore LOAD when sel >= DEPTH (no state change).
REQ-017 SHALL drive uo_out and tap_valid combinationally from registers; data written on edge N visible after edge N, before edge N+1.
REQ-018 SHALL give SHIFT latency: value D sampled at edge N appears at stage k after edge N+k.
REQ-019 SHALL drive uo_out = 0 and tap_valid = 0 when sel >= DEPTH.
REQ-020 SHALL drive full = 1 exactly when all DEPTH valid bits are 1; SHIFT while full is permitted and keeps full = 1.
REQ-021 SHALL treat ena = 0 as HOLD regardless of mode, including CLEAR.
REQ-022 SHALL use sel unchanged for both LOAD target and tap read in the same cycle; tap shows the old value until the edge.

Reset
REQ-023 SHALL on rst_n = 0, asynchronously clear all stages and valid bits, independent of clk and ena.
REQ-024 SHALL during and after reset drive uo_out = 0, uio_out = 0; uio_oe holds its constant value.
REQ-025 SHALL on reset assertion mid-SHIFT abort the shift with no partial update; first update after deassertion is the next rising edge with rst_n = 1.

Configuration
REQ-026 SHALL use macro DFF_BANK_PARITY_EN to compile the parity feature in or out.
REQ-027 SHALL with DFF_BANK_PARITY_EN defined: uio_out[5] = XOR of stage[sel][WIDTH-1:0] (even parity, 0 when sel >= DEPTH), uio_oe = 8'b1110_0000.
REQ-028 SHALL without DFF_BANK_PARITY_EN: uio_out[5] = 0, uio_oe = 8'b1100_0000, no parity logic present.

Verification
REQ-029 SHALL cover reset: rst_n low with ena=1, mode=01, ui_in=8'hFF toggling clk -> uo_out=0, uio_out=0 throughout; rst_n high then one SHIFT of 8'hA5 -> sel=0 gives uo_out=8'hA5, tap_valid=1.
REQ-030 SHALL cover shift latency (DEPTH=4): SHIFT 8'h11,8'h22,8'h33,8'h44 on consecutive edges -> sel=3 reads 8'h11, full=1; one more SHIFT 8'h55 -> sel=3 reads 8'h22, full=1.
REQ-031 SHALL cover LOAD: after reset, LOAD 8'h3C at sel=2 -> sel=2 reads 8'h3C, tap_valid=1; sel=1 reads 0, tap_valid=0; full=0.
REQ-032 SHALL cover out-of-range sel (DEPTH=4): LOAD 8'hEE at sel=5 -> no stage changes; sel=5 reads uo_out=0, tap_valid=0.
REQ-033 SHALL cover ena and CLEAR: full bank, ena=0, mode=11 for 3 edges -> contents unchanged; ena=1, mode=11, one edge -> all stages 0, full=0.
REQ-034 SHALL cover parity (macro defined): stage0=8'h07 -> uio_out[5]=1, uio_oe=8'hE0; stage0=8'h03 -> uio_out[5]=0; macro undefined -> uio_out[5]=0, uio_oe=8'hC0.
